axi_mm_host_master: RTL and testbench
=====================================

// Module: axi_mm_host_master
// PURPOSE
//  Host-driven AXI4 master for OCuLink bring-up: a 32-bit BRAM-style host port stages
//  commands and data in a DATA_W-bit buffer and pushes them into AW/W/AR FIFOs.
//  Supports multi-beat INCR bursts with automatic wlast, per-command ID/len/size,
//  captures B/R responses into FIFOs, and keeps outstanding counters and sticky error flags.
//  Sits between host_bram_ctrl and the k2o AXI interconnect port.
// PARAMETERS
//  DATA_W     128  AXI data width; multiple of 32, 32..512
//  ID_W       4    AXI ID width
//  LOG2_DEPTH 9    log2 depth of every channel FIFO
//  OUT_W      16   width of the outstanding-transaction counters
// PORTS
//  clk        in   1           clock; host port is synchronous to clk
//  rstn       in   1           asynchronous active-low reset
//  host_addr  in   15          word address (byte offset / 4)
//  host_en    in   1           access strobe
//  host_we    in   4           write enables; write when host_en && |host_we
//  host_din   in   32          write data
//  host_dout  out  32          read data, registered
//  m_aw*      out/in           AW: addr[63:0], len[7:0], size[2:0], id[ID_W], burst=INCR, others 0, valid/ready
//  m_w*       out/in           W: data[DATA_W], strb[DATA_W/8] all ones, last, valid/ready
//  m_b*       in/out           B: id, resp, valid/ready
//  m_ar*      out/in           AR: as AW
//  m_r*       in/out           R: data, id, resp, last, valid/ready
// BEHAVIOUR
//  Reset: host_dout=0, staging=0, all *valid=0, all *ready=0 until FIFOs exit reset,
//   counters=0, err=0, wbeat=0.
//  Staging: words 0x000+4k (k<DATA_W/32) hold stage[32k+:32]; R/W by host.
//  Command words (write, data ignored), each a one-cycle action:
//   0x100 AW push {id=stage[75:72], size=stage[82:80], len=stage[71:64], addr=stage[63:0]}
//   0x104 W push stage[DATA_W-1:0]; 0x108 AR push (AW layout)
//   0x10C B pop: stage <= {id,resp} zero-extended; 0x110 R pop: stage <= rdata, rinfo <= {id,resp,last}
//   0x134 err clear (W1C on host_din[3:0])
//  Read words (host_dout valid on the cycle after host_en):
//   0x114 rinfo; 0x120 status {ar_full,w_full,aw_full,r_nempty,b_nempty} bits[4:0]
//   0x128 wr_outstanding; 0x12C rd_outstanding; 0x130 err[3:0]; others read 0.
//  Error (sticky): bit0 AW/AR push while full (push dropped), bit1 W push while full (dropped),
//   bit2 B/R pop while empty (stage unchanged), bit3 outstanding counter would wrap (saturate).
//  AW/AR channels: FIFO head drives AXI directly; pop on valid&&ready.
//  wlast generation: each accepted AW pushes len into wlen_fifo (same depth).
//   W valid is asserted only when the W FIFO and wlen_fifo are both non-empty.
//   wbeat counts accepted W beats; wlast = (wbeat==wlen_head); on last beat accepted,
//   wbeat<=0 and pop wlen_fifo; otherwise wbeat++. len=0 gives single-beat bursts.
//  B/R: ready = FIFO not full; capture {id,resp}/{id,resp,last,data} on handshake.
//  Outstanding: wr +1 on AW handshake, -1 on B handshake; rd +1 on AR handshake,
//   -1 on R handshake with rlast. Simultaneous +1/-1: unchanged. Saturate at 0/max; set err bit3.
//  Simultaneous host pop and AXI-side push on the same FIFO: both take effect (fifo_bp semantics).
//  Reset mid-burst: all FIFOs, wbeat and counters clear; the AXI slave must be reset with it.
// STRUCTURE
//  Package axi_host_pkg: register offset localparams, err bit indices, aw_cmd_t struct.
//  Sub-module: reuse existing fifo_bp for all six FIFOs plus wlen_fifo; no new sub-module.
// TESTING
//  AW len=3 id=5 addr=0x1000, 4 W pushes -> 4 W beats, wlast only on beat 4, one B id=5, wr_outstanding 1->0.
//  Two AWs len=0 and len=1, 3 W pushes -> wlast on beats 1 and 3; wlen_fifo empty afterwards.
//  AR len=1, slave returns 2 beats (rlast on 2nd) -> two R pops give correct data; rinfo last=0 then 1; rd_outstanding 1->0.
//  W push with no AW queued -> m_wvalid stays 0 until an AW is accepted.
//  B pop on empty FIFO -> err=0x4, stage unchanged; W1C 0x4 at 0x134 -> err=0.
//  Fill AW FIFO (512 pushes, awready=0), push 513th -> aw_full=1, err bit0 set, 512 AWs issued after release.

Source files
------------

// File: rtl/axi_host_pkg.sv
// Shared definitions for the host-driven AXI4 master: register map, error bits, AW/AR command.
package axi_host_pkg;

   // Host word addresses (byte offset / 4)
   localparam logic [14:0] A_AW_PUSH = 15'h100 >> 2;
   localparam logic [14:0] A_W_PUSH  = 15'h104 >> 2;
   localparam logic [14:0] A_AR_PUSH = 15'h108 >> 2;
   localparam logic [14:0] A_B_POP   = 15'h10C >> 2;
   localparam logic [14:0] A_R_POP   = 15'h110 >> 2;
   localparam logic [14:0] A_RINFO   = 15'h114 >> 2;
   localparam logic [14:0] A_STATUS  = 15'h120 >> 2;
   localparam logic [14:0] A_WR_OUT  = 15'h128 >> 2;
   localparam logic [14:0] A_RD_OUT  = 15'h12C >> 2;
   localparam logic [14:0] A_ERR     = 15'h130 >> 2;
   localparam logic [14:0] A_ERR_CLR = 15'h134 >> 2;

   // Sticky error flag positions
   localparam int ERR_AX_FULL   = 0;
   localparam int ERR_W_FULL    = 1;
   localparam int ERR_POP_EMPTY = 2;
   localparam int ERR_CNT_WRAP  = 3;

   localparam logic [1:0] BURST_INCR = 2'b01;

   // One queued address-channel command (shared by AW and AR)
   typedef struct packed {
      logic [3:0]  id;
      logic [2:0]  size;
      logic [7:0]  len;
      logic [63:0] addr;
   } aw_cmd_t;

endpackage

// File: rtl/fifo_bp.sv
// First-word-fall-through FIFO with full/empty back-pressure; push while full
// and pop while empty are ignored, simultaneous push and pop both take effect.
module fifo_bp #(
   parameter int W          = 8,
   parameter int LOG2_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic [W-1:0]          mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH-1:0] rd_ptr;
   logic [LOG2_DEPTH:0]   count;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == (LOG2_DEPTH + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage write
   // NOTE: the array has no reset on purpose; only pointers/count are cleared, so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy tracking
   // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/axi_mm_host_master.sv
// Host-driven AXI4 master: a 32-bit host port stages commands/data and feeds AW/W/AR
// FIFOs; B/R responses are captured into FIFOs the host pops. Generates wlast from AW len.
module axi_mm_host_master
   import axi_host_pkg::*;
#(
   parameter int DATA_W     = 128,
   parameter int ID_W       = 4,
   parameter int LOG2_DEPTH = 9,
   parameter int OUT_W      = 16
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [14:0]         host_addr,
   input  logic                host_en,
   input  logic [3:0]          host_we,
   input  logic [31:0]         host_din,
   output logic [31:0]         host_dout,
   output logic [63:0]         m_awaddr,
   output logic [7:0]          m_awlen,
   output logic [2:0]          m_awsize,
   output logic [ID_W-1:0]     m_awid,
   output logic [1:0]          m_awburst,
   output logic                m_awlock,
   output logic [3:0]          m_awcache,
   output logic [2:0]          m_awprot,
   output logic [3:0]          m_awqos,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [ID_W-1:0]     m_bid,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic [63:0]         m_araddr,
   output logic [7:0]          m_arlen,
   output logic [2:0]          m_arsize,
   output logic [ID_W-1:0]     m_arid,
   output logic [1:0]          m_arburst,
   output logic                m_arlock,
   output logic [3:0]          m_arcache,
   output logic [2:0]          m_arprot,
   output logic [3:0]          m_arqos,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [ID_W-1:0]     m_rid,
   input  logic [1:0]          m_rresp,
   input  logic                m_rlast,
   input  logic                m_rvalid,
   output logic                m_rready
);
   localparam int          CW   = $bits(aw_cmd_t);
   localparam int          BW   = ID_W + 2;
   localparam int          RW   = ID_W + 3 + DATA_W;
   localparam logic [14:0] NW_A = 15'(DATA_W / 32);

   logic [DATA_W-1:0] stage;
   logic [31:0]       rinfo;
   logic [3:0]        err;
   logic [OUT_W-1:0]  wr_out, rd_out;
   logic [7:0]        wbeat;
   logic              rst_done;

   // Command fields live at fixed staging bit positions, even for narrow DATA_W
   logic [82:0] cmd_bits;
   logic [3:0]  unused_gap;
   aw_cmd_t     cmd, aw_head, ar_head;
   assign cmd_bits   = 83'(stage);
   assign unused_gap = cmd_bits[79:76];
   assign cmd = '{id: cmd_bits[75:72], size: cmd_bits[82:80], len: cmd_bits[71:64], addr: cmd_bits[63:0]};

   // Host decode
   logic host_wr, stage_hit;
   logic aw_push_req, w_push_req, ar_push_req, b_pop_req, r_pop_req;
   assign host_wr     = host_en && (|host_we);
   assign stage_hit   = (host_addr < NW_A);
   assign aw_push_req = host_wr && (host_addr == A_AW_PUSH);
   assign w_push_req  = host_wr && (host_addr == A_W_PUSH);
   assign ar_push_req = host_wr && (host_addr == A_AR_PUSH);
   assign b_pop_req   = host_wr && (host_addr == A_B_POP);
   assign r_pop_req   = host_wr && (host_addr == A_R_POP);

   // FIFO status and heads
   logic aw_full, aw_empty, ar_full, ar_empty, w_full, w_empty;
   logic wl_full, wl_empty, b_full, b_empty, r_full, r_empty;
   logic [DATA_W-1:0] w_head;
   logic [7:0]        wlen_head;
   logic [BW-1:0]     b_head;
   logic [RW-1:0]     r_head;

   // Channel handshakes
   logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
   assign aw_hs = m_awvalid && m_awready;
   assign ar_hs = m_arvalid && m_arready;
   assign w_hs  = m_wvalid && m_wready;
   assign b_hs  = m_bvalid && m_bready;
   assign r_hs  = m_rvalid && m_rready;

   fifo_bp #(.W(CW), .LOG2_DEPTH(LOG2_DEPTH)) u_aw_fifo (
      .clk(clk), .rstn(rstn), .push(aw_push_req), .din(cmd), .pop(aw_hs),
      .dout(aw_head), .full(aw_full), .empty(aw_empty));
   fifo_bp #(.W(CW), .LOG2_DEPTH(LOG2_DEPTH)) u_ar_fifo (
      .clk(clk), .rstn(rstn), .push(ar_push_req), .din(cmd), .pop(ar_hs),
      .dout(ar_head), .full(ar_full), .empty(ar_empty));
   fifo_bp #(.W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_w_fifo (
      .clk(clk), .rstn(rstn), .push(w_push_req), .din(stage), .pop(w_hs),
      .dout(w_head), .full(w_full), .empty(w_empty));
   fifo_bp #(.W(8), .LOG2_DEPTH(LOG2_DEPTH)) u_wlen_fifo (
      .clk(clk), .rstn(rstn), .push(aw_hs), .din(m_awlen), .pop(w_hs && m_wlast),
      .dout(wlen_head), .full(wl_full), .empty(wl_empty));
   fifo_bp #(.W(BW), .LOG2_DEPTH(LOG2_DEPTH)) u_b_fifo (
      .clk(clk), .rstn(rstn), .push(b_hs), .din({m_bid, m_bresp}), .pop(b_pop_req),
      .dout(b_head), .full(b_full), .empty(b_empty));
   fifo_bp #(.W(RW), .LOG2_DEPTH(LOG2_DEPTH)) u_r_fifo (
      .clk(clk), .rstn(rstn), .push(r_hs), .din({m_rid, m_rresp, m_rlast, m_rdata}), .pop(r_pop_req),
      .dout(r_head), .full(r_full), .empty(r_empty));

   // AXI outputs; AW waits for wlen room so every accepted burst has its length recorded
   assign m_awvalid = !aw_empty && !wl_full;
   assign m_awaddr  = aw_head.addr;
   assign m_awlen   = aw_head.len;
   assign m_awsize  = aw_head.size;
   assign m_awid    = ID_W'(aw_head.id);
   assign m_awburst = BURST_INCR;
   assign m_awlock  = 1'b0;
   assign m_awcache = '0;
   assign m_awprot  = '0;
   assign m_awqos   = '0;
   assign m_arvalid = !ar_empty;
   assign m_araddr  = ar_head.addr;
   assign m_arlen   = ar_head.len;
   assign m_arsize  = ar_head.size;
   assign m_arid    = ID_W'(ar_head.id);
   assign m_arburst = BURST_INCR;
   assign m_arlock  = 1'b0;
   assign m_arcache = '0;
   assign m_arprot  = '0;
   assign m_arqos   = '0;
   assign m_wvalid  = !w_empty && !wl_empty;
   assign m_wdata   = w_head;
   assign m_wstrb   = '1;
   assign m_wlast   = (wbeat == wlen_head);
   assign m_bready  = rst_done && !b_full;
   assign m_rready  = rst_done && !r_full;

   // Saturating outstanding-counter step: returns {wrap_attempt, next_value}
   function automatic logic [OUT_W:0] cnt_step(input logic [OUT_W-1:0] cnt, input logic inc, input logic dec);
      logic [OUT_W:0] r;
      r = {1'b0, cnt};
      if (inc && !dec)      r = (cnt == '1) ? {1'b1, cnt} : {1'b0, cnt + 1'b1};
      else if (dec && !inc) r = (cnt == '0) ? {1'b1, cnt} : {1'b0, cnt - 1'b1};
      return r;
   endfunction

   logic [OUT_W:0] wr_step, rd_step;
   assign wr_step = cnt_step(wr_out, aw_hs, b_hs);
   assign rd_step = cnt_step(rd_out, ar_hs, r_hs && m_rlast);

   logic [3:0] err_set, err_clr;
   assign err_set[ERR_AX_FULL]   = (aw_push_req && aw_full) || (ar_push_req && ar_full);
   assign err_set[ERR_W_FULL]    = w_push_req && w_full;
   assign err_set[ERR_POP_EMPTY] = (b_pop_req && b_empty) || (r_pop_req && r_empty);
   assign err_set[ERR_CNT_WRAP]  = wr_step[OUT_W] || rd_step[OUT_W];
   assign err_clr = (host_wr && host_addr == A_ERR_CLR) ? host_din[3:0] : 4'h0;

   // Read-data mux for the registered host port
   logic [31:0] rd_word;
   // NOTE: default first so every path assigns rd_word and no latch is inferred.
   always_comb begin
      rd_word = '0;
      if (stage_hit) rd_word = stage[int'(host_addr)*32 +: 32];
      else begin
         case (host_addr)
            A_RINFO:  rd_word = rinfo;
            A_STATUS: rd_word = {27'b0, ar_full, w_full, aw_full, !r_empty, !b_empty};
            A_WR_OUT: rd_word = 32'(wr_out);
            A_RD_OUT: rd_word = 32'(rd_out);
            A_ERR:    rd_word = {28'b0, err};
            default:  rd_word = '0;
         endcase
      end
   end

   // Host-visible registers, W beat tracking and counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rst_done  <= 1'b0;
         host_dout <= '0;
         stage     <= '0;
         rinfo     <= '0;
         err       <= '0;
         wr_out    <= '0;
         rd_out    <= '0;
         wbeat     <= '0;
      end else begin
         rst_done <= 1'b1;
         if (host_en) host_dout <= rd_word;
         if (b_pop_req && !b_empty) stage <= DATA_W'(b_head);
         else if (r_pop_req && !r_empty) begin
            stage <= r_head[DATA_W-1:0];
            rinfo <= 32'(r_head[DATA_W +: ID_W + 3]);
         end else if (host_wr && stage_hit) begin
            for (int b = 0; b < 4; b++)
               if (host_we[b]) stage[int'(host_addr)*32 + 8*b +: 8] <= host_din[8*b +: 8];
         end
         err    <= (err & ~err_clr) | err_set;
         wr_out <= wr_step[OUT_W-1:0];
         rd_out <= rd_step[OUT_W-1:0];
         if (w_hs) wbeat <= m_wlast ? 8'd0 : wbeat + 8'd1;
      end
   end

endmodule

// File: tb/tb_axi_mm_host_master.sv
// Self-checking bench: host-port driver, reactive AXI slave and scoreboard queues.
module tb_axi_mm_host_master;
   localparam int DATA_W = 128, ID_W = 4, LOG2_DEPTH = 9, OUT_W = 16;

   logic clk = 1'b0, rstn = 1'b0;
   logic [14:0] host_addr = '0;
   logic host_en = 1'b0;
   logic [3:0] host_we = '0;
   logic [31:0] host_din = '0, host_dout;
   logic [63:0] m_awaddr, m_araddr;
   logic [7:0] m_awlen, m_arlen;
   logic [2:0] m_awsize, m_arsize, m_awprot, m_arprot;
   logic [ID_W-1:0] m_awid, m_arid, m_bid = '0, m_rid = '0;
   logic [1:0] m_awburst, m_arburst, m_bresp = '0, m_rresp = '0;
   logic m_awlock, m_arlock, m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready;
   logic [3:0] m_awcache, m_arcache, m_awqos, m_arqos;
   logic m_awready = 1'b0, m_arready = 1'b0, m_wready = 1'b0;
   logic m_bvalid = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
   logic [DATA_W-1:0] m_wdata, m_rdata = '0;
   logic [DATA_W/8-1:0] m_wstrb;

   axi_mm_host_master #(.DATA_W(DATA_W), .ID_W(ID_W), .LOG2_DEPTH(LOG2_DEPTH), .OUT_W(OUT_W)) dut (
      .clk(clk), .rstn(rstn), .host_addr(host_addr), .host_en(host_en), .host_we(host_we),
      .host_din(host_din), .host_dout(host_dout),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awid(m_awid),
      .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
      .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arid(m_arid),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
      .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready));

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;

   task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
      logic [2:0]  size;
   } ax_t;
   typedef struct {
      logic [3:0]   id;
      logic [1:0]   resp;
      logic         last;
      logic [127:0] data;
   } rbeat_t;

   // Scoreboard and slave-model queues
   ax_t          exp_aw[$], exp_ar[$];
   logic [127:0] exp_w[$];
   logic [5:0]   exp_b[$];
   rbeat_t       exp_r[$], rsend[$];
   logic [7:0]   mdl_wlen[$];
   logic [3:0]   mdl_bid[$], bsend[$];
   int  wbeat_m = 0, beats = 0, lasts = 0, aw_cnt = 0;
   bit  aw_rdy = 1'b1, r_hold = 1'b0, b_go = 1'b0, r_go = 1'b0;
   ax_t    sl_e;
   rbeat_t sl_rb;

   // Reactive AXI slave: decides this cycle's handshakes at the falling edge
   always @(negedge clk) begin
      if (!rstn) begin
         m_awready = 0; m_arready = 0; m_wready = 0; m_bvalid = 0; m_rvalid = 0;
         b_go = 0; r_go = 0; wbeat_m = 0;
      end else begin
         if (b_go) begin void'(bsend.pop_front()); m_bvalid = 0; b_go = 0; end
         if (!m_bvalid && bsend.size() > 0) begin
            m_bvalid = 1; m_bid = bsend[0]; m_bresp = 2'($urandom_range(0, 3));
         end
         b_go = m_bvalid && m_bready;
         if (b_go) exp_b.push_back({m_bid, m_bresp});

         if (r_go) begin void'(rsend.pop_front()); m_rvalid = 0; r_go = 0; end
         if (!m_rvalid && !r_hold && rsend.size() > 0) begin
            m_rvalid = 1; m_rid = rsend[0].id; m_rresp = rsend[0].resp;
            m_rlast = rsend[0].last; m_rdata = rsend[0].data;
         end
         r_go = m_rvalid && m_rready;
         if (r_go) exp_r.push_back(rsend[0]);

         m_awready = aw_rdy;
         if (m_awvalid && m_awready) begin
            aw_cnt++;
            if (exp_aw.size() == 0) check("aw_queue", 0, 1);
            else begin
               sl_e = exp_aw.pop_front();
               check("aw_addr", m_awaddr, sl_e.addr);
               check("aw_len", m_awlen, sl_e.len);
               check("aw_id", m_awid, sl_e.id);
               check("aw_burst", m_awburst, 2'b01);
            end
            mdl_wlen.push_back(m_awlen);
            mdl_bid.push_back(m_awid);
         end

         m_arready = 1;
         if (m_arvalid && m_arready) begin
            if (exp_ar.size() == 0) check("ar_queue", 0, 1);
            else begin
               sl_e = exp_ar.pop_front();
               check("ar_addr", m_araddr, sl_e.addr);
               check("ar_len", m_arlen, sl_e.len);
               check("ar_id", m_arid, sl_e.id);
            end
            for (int k = 0; k <= int'(m_arlen); k++) begin
               sl_rb.id = m_arid; sl_rb.resp = 2'($urandom_range(0, 3));
               sl_rb.last = (k == int'(m_arlen));
               sl_rb.data = {$urandom, $urandom, $urandom, $urandom};
               rsend.push_back(sl_rb);
            end
         end

         m_wready = 1'($urandom_range(0, 1));
         if (m_wvalid && m_wready) begin
            beats++;
            if (m_wlast) lasts++;
            if (exp_w.size() == 0) check("w_queue", 0, 1);
            else check("w_data", m_wdata, exp_w.pop_front());
            check("w_strb", m_wstrb, 16'hFFFF);
            if (mdl_wlen.size() == 0) check("w_without_aw", 0, 1);
            else begin
               check("w_last", m_wlast, (wbeat_m == int'(mdl_wlen[0])));
               if (wbeat_m == int'(mdl_wlen[0])) begin
                  wbeat_m = 0;
                  void'(mdl_wlen.pop_front());
                  bsend.push_back(mdl_bid.pop_front());
               end else wbeat_m++;
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_wr(input logic [11:0] off, input logic [31:0] d);
      @(negedge clk);
      host_en = 1; host_we = 4'hF; host_addr = 15'(off >> 2); host_din = d;
      @(negedge clk);
      host_en = 0; host_we = 4'h0;
   endtask

   task automatic host_rd(input logic [11:0] off, output logic [31:0] d);
      @(negedge clk);
      host_en = 1; host_we = 4'h0; host_addr = 15'(off >> 2);
      @(negedge clk);
      host_en = 0;
      d = host_dout;
   endtask

   task automatic set_stage(input logic [127:0] v);
      for (int k = 0; k < 4; k++) host_wr(12'(4 * k), v[32*k +: 32]);
   endtask

   task automatic push_ax(input bit is_ar, input logic [3:0] id, input logic [7:0] len,
                          input logic [63:0] addr, input bit expect_it);
      ax_t e;
      e.addr = addr; e.len = len; e.id = id; e.size = 3'd4;
      set_stage({45'b0, e.size, 4'b0, id, len, addr});
      host_wr(is_ar ? 12'h108 : 12'h100, 32'h0);
      if (expect_it) begin
         if (is_ar) exp_ar.push_back(e);
         else exp_aw.push_back(e);
      end
   endtask

   task automatic push_w(input logic [127:0] d);
      set_stage(d);
      host_wr(12'h104, 32'h0);
      exp_w.push_back(d);
   endtask

   task automatic pop_b(input string tag);
      logic [31:0] d;
      host_wr(12'h10C, 32'h0);
      host_rd(12'h000, d);
      if (exp_b.size() == 0) check({tag, "_queue"}, 0, 1);
      else check(tag, d, {26'b0, exp_b.pop_front()});
   endtask

   task automatic pop_r(input string tag, input logic exp_last);
      logic [31:0]  d;
      logic [127:0] got;
      rbeat_t       e;
      host_wr(12'h110, 32'h0);
      for (int k = 0; k < 4; k++) begin
         host_rd(12'(4 * k), d);
         got[32*k +: 32] = d;
      end
      host_rd(12'h114, d);
      if (exp_r.size() == 0) check({tag, "_queue"}, 0, 1);
      else begin
         e = exp_r.pop_front();
         check({tag, "_data"}, got, e.data);
         check({tag, "_rinfo"}, d, {25'b0, e.id, e.resp, e.last});
         check({tag, "_last"}, d[0], exp_last);
      end
   endtask

   initial begin
      logic [31:0] d;
      int b0, l0, a0;

      wait_cycles(3);
      check("rst_awvalid", m_awvalid, 0);
      check("rst_wvalid", m_wvalid, 0);
      check("rst_arvalid", m_arvalid, 0);
      check("rst_bready", m_bready, 0);
      check("rst_rready", m_rready, 0);
      check("rst_dout", host_dout, 0);
      rstn = 1;
      wait_cycles(2);
      check("post_rst_bready", m_bready, 1);
      check("post_rst_rready", m_rready, 1);
      host_rd(12'h120, d); check("rst_status", d, 0);
      host_rd(12'h130, d); check("rst_err", d, 0);
      host_rd(12'h128, d); check("rst_wr_out", d, 0);
      host_rd(12'h000, d); check("rst_stage", d, 0);

      // 4-beat burst, id 5
      push_ax(0, 4'd5, 8'd3, 64'h1000, 1);
      wait_cycles(6);
      host_rd(12'h128, d); check("t1_wr_out_1", d, 1);
      check("t1_wvalid_idle", m_wvalid, 0);
      b0 = beats; l0 = lasts;
      for (int i = 0; i < 4; i++) push_w({$urandom, $urandom, $urandom, $urandom});
      wait_cycles(30);
      check("t1_beats", beats - b0, 4);
      check("t1_lasts", lasts - l0, 1);
      host_rd(12'h128, d); check("t1_wr_out_0", d, 0);
      pop_b("t1_b");
      host_rd(12'h000, d); check("t1_bid", d[5:2], 5);

      // len=0 then len=1: wlast on beats 1 and 3
      push_ax(0, 4'd1, 8'd0, 64'h3000, 1);
      push_ax(0, 4'd2, 8'd1, 64'h4000, 1);
      b0 = beats; l0 = lasts;
      for (int i = 0; i < 3; i++) push_w({$urandom, $urandom, $urandom, $urandom});
      wait_cycles(30);
      check("t2_beats", beats - b0, 3);
      check("t2_lasts", lasts - l0, 2);
      check("t2_wvalid_drained", m_wvalid, 0);
      pop_b("t2_b0");
      pop_b("t2_b1");

      // W data without an AW must wait
      b0 = beats;
      push_w({$urandom, $urandom, $urandom, $urandom});
      wait_cycles(10);
      check("t4_wvalid_held", m_wvalid, 0);
      check("t4_no_beat", beats - b0, 0);
      push_ax(0, 4'd7, 8'd0, 64'h5000, 1);
      wait_cycles(20);
      check("t4_beat_after_aw", beats - b0, 1);
      pop_b("t4_b");

      // Read burst of 2
      r_hold = 1;
      push_ax(1, 4'd3, 8'd1, 64'h2000, 1);
      wait_cycles(6);
      host_rd(12'h12C, d); check("t3_rd_out_1", d, 1);
      r_hold = 0;
      wait_cycles(10);
      host_rd(12'h12C, d); check("t3_rd_out_0", d, 0);
      pop_r("t3_r0", 1'b0);
      pop_r("t3_r1", 1'b1);

      // Pop on empty B FIFO leaves stage alone and sets err bit2
      set_stage(128'h0123_4567_89AB_CDEF_A5A5_5A5A_DEAD_BEEF);
      host_wr(12'h10C, 32'h0);
      host_rd(12'h130, d); check("t5_err_pop_empty", d, 4);
      host_rd(12'h000, d); check("t5_stage_kept", d, 32'hDEAD_BEEF);
      host_wr(12'h134, 32'h4);
      host_rd(12'h130, d); check("t5_err_cleared", d, 0);

      // Fill AW FIFO with awready low, overflow once, then release
      aw_rdy = 0;
      a0 = aw_cnt;
      for (int i = 0; i < 512; i++) push_ax(0, 4'(i), 8'd0, 64'(i * 16), 1);
      push_ax(0, 4'hF, 8'd0, 64'hFFFF_0000, 0);
      wait_cycles(3);
      check("t6_no_aw_yet", aw_cnt - a0, 0);
      host_rd(12'h120, d); check("t6_status_aw_full", d, 32'h4);
      host_rd(12'h130, d); check("t6_err_full", d, 1);
      aw_rdy = 1;
      wait_cycles(600);
      check("t6_aw_issued", aw_cnt - a0, 512);
      check("t6_aw_left", exp_aw.size(), 0);
      host_rd(12'h128, d); check("t6_wr_out", d, 512);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
